mips_pipe_skid_reg: RTL and testbench
=====================================

Name: mips_pipe_skid_reg

Overview:
Parametrised pipeline-stage register for the MIPS pipeline, replacing the fixed four-field stage latches (IR/PC4/AO/DR style).
- Carries N_CH channels of DW bits each between two stages.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, flush-to-bubble and saturating stall/flush counters.
- Sits between any two pipeline stages, e.g. MEM->WB.

Parameters:
DW, 32, width of one channel
N_CH, 4, number of channels (channel 0 = IR, by convention)
PC_CH, 1, index of the channel that resets to PC_RST (PC4 field)
PC_RST, 32'h00003000, reset/bubble value of channel PC_CH; all other channels reset/bubble to 0
CNT_W, 16, width of the statistic counters

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
Flush  in  1  discard all held entries this cycle (branch/exception kill)
in_valid  in  1  upstream has data
in_ready  out  1  stage can accept data
in_data  in  N_CH*DW  channel k at bits [k*DW +: DW]
out_valid  out  1  out_data holds a real instruction
out_ready  in  1  downstream accepts out_data
out_data  out  N_CH*DW  main entry; bubble pattern when out_valid=0
occupancy  out  2  number of valid entries, 0..2
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
flush_cnt  out  CNT_W  flushes that killed at least one valid entry, saturating

Behaviour:
- Storage and handshake:
  - Two entries, main (drives out_data) and skid, each with a valid bit.
  - Bubble pattern: all channels 0, except channel PC_CH = PC_RST.
  - in_ready = !skid_valid. This is purely registered; there is no combinational path from out_ready to in_ready.
  - Accept event: acc = in_valid & in_ready. Pop event: pop = out_valid & out_ready.
- Reset (highest priority, sampled on posedge Clk):
  - main/skid valid = 0; main and skid data = bubble pattern.
  - Counters = 0.
  - Outputs after the reset edge: out_valid=0, in_ready=1, occupancy=0.
- Flush (next priority):
  - Both valid bits cleared; main data = bubble pattern.
  - Any acc in the same cycle is dropped.
  - flush_cnt += 1 if occupancy != 0 before the edge (saturating).
  - stall_cnt still updates for that cycle.
- Normal update, per edge:
  - main empty or pop, skid valid: main <= skid; skid <= input if acc, else empty.
  - main empty or pop, skid empty: main <= input if acc; otherwise main <= bubble pattern, valid 0.
  - main valid and no pop: main holds; on acc, skid <= input. acc cannot occur while skid is valid.
- Latency and throughput:
  - 1 cycle from acc to out_valid when the stage is empty.
  - Sustained 1 transfer/cycle when out_ready=1.
  - Strict FIFO order; no drop and no duplication.
- Counters:
  - stall_cnt increments when out_valid & !out_ready.
  - Both counters hold at 2^CNT_W-1.
- Width rules:
  - in_data/out_data widths are exactly N_CH*DW.
  - PC_RST is truncated to DW.
  - PC_CH >= N_CH means no channel uses PC_RST; enforce with an elaboration-time check that errors out.
- Data stability: while out_valid & !out_ready, out_data must remain stable.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - default DW / N_CH / PC_RST constants
  - channel index constants (CH_IR=0, CH_PC4=1, CH_AO=2, CH_DR=3)
  - a function returning the bubble pattern
- One sub-module is natural: mips_sat_counter (CNT_W, inc, clr, q), instantiated twice.

Test Plan:
- Reset: hold Reset for 2 cycles -> out_valid=0, in_ready=1, occupancy=0, channel1=32'h3000, other channels 0, counters 0.
- Streaming: out_ready=1, push IR=0x8C010004, 0x00221820, 0xAC030008 on consecutive cycles -> each appears 1 cycle later in order; in_ready stays 1; occupancy stays 1.
- Back-pressure: out_ready=0 after item A is in main; push B -> occupancy=2, in_ready=0, out_data=A stable.
  - Release out_ready -> A, then B, popped on successive cycles.
  - stall_cnt equals the number of held cycles.
- Flush with full skid plus same-cycle in_valid -> next cycle occupancy=0, out_valid=0, out_data=bubble pattern, flush_cnt=1, the input item is never output.
- Flush on an empty stage -> flush_cnt unchanged.
- Reset mid-operation with occupancy=2 and out_ready=0 -> all state returns to reset values in one cycle; stall_cnt=0.
- Saturation (CNT_W=4): hold a stall for 20 cycles -> stall_cnt=15 and stays at 15.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared constants and helpers for the MIPS pipeline stage registers.
package mips_pipe_pkg;

    // Default geometry of a classic four-field stage latch.
    localparam int          DW_DEF     = 32;
    localparam int          N_CH_DEF   = 4;
    localparam logic [31:0] PC_RST_DEF = 32'h0000_3000;
    localparam int          CNT_W_DEF  = 16;

    // Channel roles inside a stage register.
    localparam int CH_IR  = 0;
    localparam int CH_PC4 = 1;
    localparam int CH_AO  = 2;
    localparam int CH_DR  = 3;

    // Widest bus the bubble helper can describe.
    localparam int MAX_BUS_W = 1024;

    // Bubble pattern: all channels zero except channel pc_ch, which carries
    // pc_rst truncated to dw bits. A pc_ch outside 0..n_ch-1 yields all zeros.
    function automatic logic [MAX_BUS_W-1:0] bubble_pattern(
        input int          dw,
        input int          n_ch,
        input int          pc_ch,
        input logic [31:0] pc_rst
    );
        logic [31:0]          chan;
        logic [MAX_BUS_W-1:0] res;
        res  = '0;
        chan = (dw >= 32) ? pc_rst : (pc_rst & ((32'd1 << dw) - 32'd1));
        if (pc_ch >= 0 && pc_ch < n_ch) begin
            res = MAX_BUS_W'(chan) << (pc_ch * dw);
        end
        return res;
    endfunction

endpackage

// File: rtl/mips_pipe_skid_reg_if.sv
// Valid/ready bus between two pipeline stages, carrying N_CH channels of DW bits.
interface mips_pipe_skid_reg_if #(
    parameter int DW   = 32,
    parameter int N_CH = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [N_CH*DW-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N_CH*DW-1:0] out_data;

    // Surrounding pipeline: feeds the stage and consumes its output.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The stage register itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mips_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module mips_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] q_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;
endmodule

// File: rtl/mips_pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble and saturating stall/flush statistics.
module mips_pipe_skid_reg
    import mips_pipe_pkg::*;
#(
    parameter int          DW     = DW_DEF,
    parameter int          N_CH   = N_CH_DEF,
    parameter int          PC_CH  = CH_PC4,
    parameter logic [31:0] PC_RST = PC_RST_DEF,
    parameter int          CNT_W  = CNT_W_DEF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Flush,
    mips_pipe_skid_reg_if.slave     bus,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);
    localparam int BW = N_CH * DW;

    localparam logic [BW-1:0] BUBBLE =
        BW'(bubble_pattern(DW, N_CH, PC_CH, PC_RST));

    // A PC channel that does not exist would silently lose the PC4 reset value.
    if (PC_CH >= N_CH) begin : g_bad_pc_ch
        $error("mips_pipe_skid_reg: PC_CH (%0d) must be below N_CH (%0d)", PC_CH, N_CH);
    end
    if (BW > MAX_BUS_W) begin : g_bad_width
        $error("mips_pipe_skid_reg: N_CH*DW (%0d) exceeds %0d", BW, MAX_BUS_W);
    end

    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [BW-1:0] main_data_q,  main_data_d;
    logic [BW-1:0] skid_data_q,  skid_data_d;

    logic acc;
    logic pop;

    // in_ready depends only on registered state, so out_ready never
    // reaches the upstream stage combinationally.
    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_valid = main_valid_q;
    assign bus.out_data  = main_data_q;

    assign acc = bus.in_valid & bus.in_ready;
    assign pop = main_valid_q & bus.out_ready;

    // The skid entry is only ever valid while main is valid, so the sum is the
    // count of held entries.
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    // Next-state of the two entries: flush kills, otherwise refill main from
    // skid or input, and park the input in skid while main is stalled.
    always_comb begin
        // NOTE: every variable gets its hold value first so no branch can infer a latch.
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;

        if (Flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_data_d  = BUBBLE;
        end else if (!main_valid_q || pop) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = acc;
                if (acc) begin
                    skid_data_d = bus.in_data;
                end
            end else if (acc) begin
                main_valid_d = 1'b1;
                main_data_d  = bus.in_data;
            end else begin
                main_valid_d = 1'b0;
                main_data_d  = BUBBLE;
            end
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = bus.in_data;
        end
    end

    // Entry registers; reset loads the bubble pattern into both data slots.
    always_ff @(posedge Clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            // NOTE: data slots are reset too, because out_data must show the bubble pattern right after reset.
            main_data_q  <= BUBBLE;
            skid_data_q  <= BUBBLE;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    // Cycles in which a real instruction waits on downstream.
    mips_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr_i (1'b0),
        .inc_i (main_valid_q & ~bus.out_ready),
        .q_o   (stall_cnt)
    );

    // Flushes that actually discarded at least one held entry.
    mips_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr_i (1'b0),
        .inc_i (Flush & (occupancy != 2'd0)),
        .q_o   (flush_cnt)
    );
endmodule

// File: tb/tb_mips_pipe_skid_reg.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a depth-2 FIFO reference model.
module tb_mips_pipe_skid_reg;
    import mips_pipe_pkg::*;

    localparam int          TDW  = 32;
    localparam int          TN   = 4;
    localparam int          TCW  = 4;
    localparam int          CMAX = 15;
    localparam logic [127:0] BUBBLE = {32'h0, 32'h0, 32'h0000_3000, 32'h0};

    logic           Clk   = 1'b0;
    logic           Reset = 1'b1;
    logic           Flush = 1'b0;
    logic [1:0]     occupancy;
    logic [TCW-1:0] stall_cnt;
    logic [TCW-1:0] flush_cnt;

    mips_pipe_skid_reg_if #(.DW(TDW), .N_CH(TN)) bus ();

    mips_pipe_skid_reg #(
        .DW     (TDW),
        .N_CH   (TN),
        .PC_CH  (1),
        .PC_RST (32'h0000_3000),
        .CNT_W  (TCW)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Flush     (Flush),
        .bus       (bus),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a FIFO of at most two items plus two saturating counts.
    logic [127:0] mq[$];
    int           m_stall = 0;
    int           m_flush = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input bit rdy, input logic [127:0] d);
        bus.in_valid  = v;
        bus.out_ready = rdy;
        bus.in_data   = d;
    endtask

    function automatic logic [127:0] item(input logic [31:0] ir);
        return {$urandom(), $urandom(), $urandom(), ir};
    endfunction

    // Advance one clock: update the model from the inputs seen at the edge,
    // then compare every DUT output against it shortly after the edge.
    task automatic step();
        bit pop;
        bit acc;
        @(posedge Clk);
        if (Reset) begin
            mq.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (mq.size() > 0 && !bus.out_ready && m_stall < CMAX) m_stall++;
            if (Flush) begin
                if (mq.size() != 0 && m_flush < CMAX) m_flush++;
                mq.delete();
            end else begin
                pop = (mq.size() > 0) && bus.out_ready;
                acc = bus.in_valid && (mq.size() < 2);
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back(bus.in_data);
            end
        end
        #1;
        check("out_valid", bus.out_valid, mq.size() > 0);
        check("in_ready",  bus.in_ready,  mq.size() < 2);
        check("occupancy", occupancy,     mq.size());
        check("out_data",  bus.out_data,  (mq.size() > 0) ? mq[0] : BUBBLE);
        check("stall_cnt", stall_cnt,     m_stall);
        check("flush_cnt", flush_cnt,     m_flush);
    endtask

    logic [127:0] a_item;
    logic [127:0] b_item;

    initial begin
        drive(1'b0, 1'b0, '0);

        // Reset held for two cycles.
        Reset = 1'b1;
        step();
        step();
        check("rst_pc4", bus.out_data[CH_PC4*32 +: 32], 32'h0000_3000);
        check("rst_ir",  bus.out_data[CH_IR*32 +: 32],  32'h0);
        Reset = 1'b0;

        // Streaming at full rate.
        drive(1'b1, 1'b1, item(32'h8C01_0004));
        step();
        check("stream_ir0", bus.out_data[CH_IR*32 +: 32], 32'h8C01_0004);
        drive(1'b1, 1'b1, item(32'h0022_1820));
        step();
        check("stream_ir1", bus.out_data[CH_IR*32 +: 32], 32'h0022_1820);
        drive(1'b1, 1'b1, item(32'hAC03_0008));
        step();
        check("stream_ir2", bus.out_data[CH_IR*32 +: 32], 32'hAC03_0008);
        drive(1'b0, 1'b1, '0);
        step();

        // Back-pressure with the skid entry filled.
        a_item = item(32'h1111_0001);
        b_item = item(32'h2222_0002);
        drive(1'b1, 1'b1, a_item);
        step();
        drive(1'b1, 1'b0, b_item);
        step();
        check("bp_occ2",  occupancy,    2'd2);
        check("bp_hold_a", bus.out_data, a_item);
        drive(1'b0, 1'b0, '0);
        step();
        step();
        check("bp_stable_a", bus.out_data, a_item);
        drive(1'b0, 1'b1, '0);
        step();
        check("bp_pop_b",  bus.out_data, b_item);
        check("bp_stalls", stall_cnt,    4'd3);
        step();

        // Flush with a full skid plus a same-cycle input.
        drive(1'b1, 1'b0, item(32'h3333_0003));
        step();
        drive(1'b1, 1'b0, item(32'h4444_0004));
        step();
        Flush = 1'b1;
        drive(1'b1, 1'b0, item(32'h5555_0005));
        step();
        Flush = 1'b0;
        check("flush_occ",    occupancy,    2'd0);
        check("flush_bubble", bus.out_data, BUBBLE);
        check("flush_cnt1",   flush_cnt,    4'd1);
        drive(1'b0, 1'b1, '0);
        step();
        step();

        // Flush on an empty stage is not counted.
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("flush_empty", flush_cnt, 4'd1);

        // Reset in the middle of a stall with both entries held.
        drive(1'b1, 1'b0, item(32'h6666_0006));
        step();
        drive(1'b1, 1'b0, item(32'h7777_0007));
        step();
        Reset = 1'b1;
        drive(1'b1, 1'b0, item(32'h8888_0008));
        step();
        Reset = 1'b0;
        check("midrst_stall", stall_cnt, 4'd0);
        check("midrst_occ",   occupancy, 2'd0);

        // Long stall saturates the 4-bit stall counter.
        drive(1'b1, 1'b0, item(32'h9999_0009));
        step();
        drive(1'b0, 1'b0, '0);
        for (int i = 0; i < 20; i++) step();
        check("sat_stall", stall_cnt, 4'd15);
        step();
        check("sat_hold", stall_cnt, 4'd15);

        // Random traffic with occasional flush and reset.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(3) != 0), ($urandom_range(2) != 0), item($urandom()));
            Flush = ($urandom_range(15) == 0);
            Reset = ($urandom_range(199) == 0);
            step();
        end
        Reset = 1'b0;
        Flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
